// File: rtl/text_console_writer.sv
// text_console_writer
// Turns a valid/ready stream of ASCII bytes into single-cycle write
// transactions on the 80x30 character matrix. It keeps a cursor and handles
// CR, LF, BS and FF. Scrolling advances a circular top-row offset instead of
// moving memory. The renderer starts each frame at top_addr and wraps at
// COLS*ROWS.
//
// Ports
//   clk_pix, rst_pix_n  pixel clock; asynchronous active-low reset
//   in_data, in_valid   incoming ASCII byte and its qualifier
//   in_ready            high only in IDLE; a byte is taken when valid && ready
//   cm_we/addr/data     registered write port to the character matrix
//   top_row, top_addr   physical row shown at the top, and top_row*COLS
//   cur_col, cur_row    logical cursor position
`timescale 1ns/1ps

module text_console_writer #(
  parameter int COLS  = 80,
  parameter int ROWS  = 30,
  parameter int ADDRW = 12
) (
  input  logic             clk_pix,
  input  logic             rst_pix_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             cm_we,
  output logic [ADDRW-1:0] cm_addr,
  output logic [7:0]       cm_data,
  output logic [4:0]       top_row,
  output logic [ADDRW-1:0] top_addr,
  output logic [6:0]       cur_col,
  output logic [4:0]       cur_row
);

  localparam int         TOTAL = COLS * ROWS;
  localparam logic [7:0] SPACE = 8'h20;

  typedef enum logic [1:0] {CLEAR_ALL, IDLE, CLEAR_LINE} state_t;

  state_t           state_q, state_d;
  logic [ADDRW-1:0] clr_q, clr_d;             // clear progress: address or column
  logic [ADDRW-1:0] line_base_q, line_base_d; // first address of the row being blanked
  logic             cm_we_q, cm_we_d;
  logic [ADDRW-1:0] cm_addr_q, cm_addr_d;
  logic [7:0]       cm_data_q, cm_data_d;
  logic [4:0]       top_row_q, top_row_d;
  logic [ADDRW-1:0] top_addr_q, top_addr_d;
  logic [6:0]       cur_col_q, cur_col_d;
  logic [4:0]       cur_row_q, cur_row_d;

  logic [5:0]       phys_sum;
  logic [4:0]       phys;
  logic [ADDRW-1:0] wr_addr;
  logic             newline;

  // Row start address, r*80 built from shifts (r*64 + r*16).
  function automatic logic [ADDRW-1:0] row_base(input logic [4:0] r);
    return ADDRW'({r, 6'b0}) + ADDRW'({r, 4'b0});
  endfunction

  // Logical cursor row mapped onto the circular physical row layout.
  assign phys_sum = {1'b0, top_row_q} + {1'b0, cur_row_q};
  assign phys     = (phys_sum >= 6'(ROWS)) ? 5'(phys_sum - 6'(ROWS)) : phys_sum[4:0];
  assign wr_addr  = row_base(phys) + ADDRW'(cur_col_q);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    clr_d       = clr_q;
    line_base_d = line_base_q;
    cm_we_d     = 1'b0;
    cm_addr_d   = cm_addr_q;
    cm_data_d   = cm_data_q;
    top_row_d   = top_row_q;
    top_addr_d  = row_base(top_row_q);
    cur_col_d   = cur_col_q;
    cur_row_d   = cur_row_q;
    newline     = 1'b0;

    case (state_q)
      CLEAR_ALL: begin
        // One idle cycle after the last write lets in_ready rise only once
        // the final blank has been presented.
        if (clr_q == ADDRW'(TOTAL)) begin
          state_d = IDLE;
          clr_d   = '0;
        end else begin
          cm_we_d   = 1'b1;
          cm_addr_d = clr_q;
          cm_data_d = SPACE;
          clr_d     = clr_q + ADDRW'(1);
        end
      end

      CLEAR_LINE: begin
        if (clr_q == ADDRW'(COLS)) begin
          state_d = IDLE;
          clr_d   = '0;
        end else begin
          cm_we_d   = 1'b1;
          cm_addr_d = line_base_q + clr_q;
          cm_data_d = SPACE;
          clr_d     = clr_q + ADDRW'(1);
        end
      end

      IDLE: begin
        if (in_valid) begin
          if (in_data >= 8'h20 && in_data <= 8'h7E) begin
            cm_we_d   = 1'b1;
            cm_addr_d = wr_addr;
            cm_data_d = in_data;
            if (cur_col_q == 7'(COLS - 1)) begin
              cur_col_d = '0;
              newline   = 1'b1;
            end else begin
              cur_col_d = cur_col_q + 7'd1;
            end
          end else if (in_data == 8'h0A) begin
            cur_col_d = '0;
            newline   = 1'b1;
          end else if (in_data == 8'h0D) begin
            cur_col_d = '0;
          end else if (in_data == 8'h08) begin
            cur_col_d = (cur_col_q == 7'd0) ? 7'd0 : cur_col_q - 7'd1;
          end else if (in_data == 8'h0C) begin
            // The first blank (addr 0) goes out together with the state change.
            state_d   = CLEAR_ALL;
            top_row_d = '0;
            cur_col_d = '0;
            cur_row_d = '0;
            cm_we_d   = 1'b1;
            cm_addr_d = '0;
            cm_data_d = SPACE;
            clr_d     = ADDRW'(1);
          end

          if (newline) begin
            if (cur_row_q != 5'(ROWS - 1)) begin
              cur_row_d = cur_row_q + 5'd1;
            end else begin
              // Scroll: the old top row becomes the new bottom row. It is
              // the one to blank.
              top_row_d   = (top_row_q == 5'(ROWS - 1)) ? 5'd0 : top_row_q + 5'd1;
              line_base_d = row_base(top_row_q);
              clr_d       = '0;
              state_d     = CLEAR_LINE;
            end
          end
        end
      end

      default: begin
        state_d = CLEAR_ALL;
        clr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state_q     <= CLEAR_ALL;
      clr_q       <= '0;
      line_base_q <= '0;
      cm_we_q     <= 1'b0;
      cm_addr_q   <= '0;
      cm_data_q   <= '0;
      top_row_q   <= '0;
      top_addr_q  <= '0;
      cur_col_q   <= '0;
      cur_row_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // values, whatever order the lines are written in.
      state_q     <= state_d;
      clr_q       <= clr_d;
      line_base_q <= line_base_d;
      cm_we_q     <= cm_we_d;
      cm_addr_q   <= cm_addr_d;
      cm_data_q   <= cm_data_d;
      top_row_q   <= top_row_d;
      top_addr_q  <= top_addr_d;
      cur_col_q   <= cur_col_d;
      cur_row_q   <= cur_row_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign cm_we    = cm_we_q;
  assign cm_addr  = cm_addr_q;
  assign cm_data  = cm_data_q;
  assign top_row  = top_row_q;
  assign top_addr = top_addr_q;
  assign cur_col  = cur_col_q;
  assign cur_row  = cur_row_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Self-checking bench for text_console_writer. A behavioural model of the
// cursor pushes the expected matrix writes into a queue as bytes are
// accepted. A monitor pops and compares one entry for every cm_we cycle.
`timescale 1ns/1ps

module tb_text_console_writer;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int ADDRW = 12;

  logic             clk_pix   = 1'b0;
  logic             rst_pix_n = 1'b1;
  logic [7:0]       in_data   = 8'h00;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic             cm_we;
  logic [ADDRW-1:0] cm_addr;
  logic [7:0]       cm_data;
  logic [4:0]       top_row;
  logic [ADDRW-1:0] top_addr;
  logic [6:0]       cur_col;
  logic [4:0]       cur_row;

  text_console_writer #(.COLS(COLS), .ROWS(ROWS), .ADDRW(ADDRW)) dut (
    .clk_pix   (clk_pix),
    .rst_pix_n (rst_pix_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cm_we     (cm_we),
    .cm_addr   (cm_addr),
    .cm_data   (cm_data),
    .top_row   (top_row),
    .top_addr  (top_addr),
    .cur_col   (cur_col),
    .cur_row   (cur_row)
  );

  always #5 clk_pix = ~clk_pix;

  typedef struct packed {
    logic [ADDRW-1:0] addr;
    logic [7:0]       data;
  } wr_t;

  wr_t sb[$];
  wr_t exp_w;
  int  errors = 0;
  int  checks = 0;
  int  m_col  = 0;
  int  m_row  = 0;
  int  m_top  = 0;
  time t_last = 0;
  time t_prev = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every write the DUT makes must be the next expected one.
  always @(negedge clk_pix) begin
    if (rst_pix_n && cm_we) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_write: observed addr=%0d data=%0h expected=no write", cm_addr, cm_data);
      end
      if (sb.size() > 0) begin
        exp_w = sb.pop_front();
        checks++;
        assert ({cm_addr, cm_data} === exp_w) else begin
          errors++;
          $error("FAIL write: observed addr=%0d data=%0h expected addr=%0d data=%0h",
                 cm_addr, cm_data, exp_w.addr, exp_w.data);
        end
      end
      t_prev = t_last;
      t_last = $time;
    end
  end

  task automatic push_w(input int addr, input logic [7:0] data);
    wr_t w;
    w.addr = ADDRW'(addr);
    w.data = data;
    sb.push_back(w);
  endtask

  task automatic push_clear_all();
    for (int i = 0; i < COLS * ROWS; i++) push_w(i, 8'h20);
  endtask

  task automatic model_nl();
    if (m_row < ROWS - 1) begin
      m_row++;
    end else begin
      for (int i = 0; i < COLS; i++) push_w(m_top * COLS + i, 8'h20);
      m_top = (m_top + 1) % ROWS;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_w(((m_top + m_row) % ROWS) * COLS + m_col, b);
      if (m_col == COLS - 1) begin
        m_col = 0;
        model_nl();
      end else begin
        m_col++;
      end
    end else if (b == 8'h0A) begin
      m_col = 0;
      model_nl();
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h08) begin
      if (m_col > 0) m_col--;
    end else if (b == 8'h0C) begin
      push_clear_all();
      m_top = 0;
      m_col = 0;
      m_row = 0;
    end
  endtask

  // Called at a falling edge. Presents b, waits for acceptance, and returns at
  // the falling edge after the accepting edge with in_valid low.
  task automatic send(input logic [7:0] b);
    int n;
    n        = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 6000) begin
      @(negedge clk_pix);
      n++;
    end
    check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk_pix);
    model_byte(b);
    @(negedge clk_pix);
    in_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!in_ready && n < 6000) begin
      @(negedge clk_pix);
      n++;
    end
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk_pix);
  endtask

  initial begin
    int n;

    // Reset values.
    rst_pix_n = 1'b0;
    idle(3);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_cm_we",    32'(cm_we),    32'd0);
    check("rst_cm_addr",  32'(cm_addr),  32'd0);
    check("rst_cm_data",  32'(cm_data),  32'd0);
    check("rst_top",      32'({top_row, top_addr}), 32'd0);
    check("rst_cursor",   32'({cur_row, cur_col}),  32'd0);

    // Start a clear, then reset in the middle of it.
    push_clear_all();
    #1 rst_pix_n = 1'b1;
    idle(100);
    check("mid_clear_we", 32'(cm_we), 32'd1);
    @(posedge clk_pix);
    #2 rst_pix_n = 1'b0;
    #1;
    check("async_rst_we",    32'(cm_we),    32'd0);
    check("async_rst_addr",  32'(cm_addr),  32'd0);
    check("async_rst_ready", 32'(in_ready), 32'd0);
    sb.delete();
    push_clear_all();

    // Full clear after release: 2400 writes, ready one cycle after the last.
    @(negedge clk_pix);
    #1 rst_pix_n = 1'b1;
    wait_ready(n);
    check("clear_all_cycles", 32'(n), 32'd2401);
    check("clear_all_sb_empty", 32'(sb.size()), 32'd0);
    check("clear_all_cursor", 32'({cur_row, cur_col}), 32'd0);

    // Back-to-back printable bytes.
    send(8'h41);
    send(8'h42);
    idle(1);
    check("ab_cur_col", 32'(cur_col), 32'd2);
    check("ab_consecutive", 32'(t_last - t_prev), 32'd10);
    check("ab_sb_empty", 32'(sb.size()), 32'd0);

    // A full row wraps to the next row without clearing.
    send(8'h0D);
    for (int i = 0; i < COLS; i++) send(8'h41);
    idle(1);
    check("row_wrap_cursor", 32'({cur_row, cur_col}), 32'({5'd1, 7'd0}));
    check("row_wrap_ready", 32'(in_ready), 32'd1);
    check("row_wrap_sb_empty", 32'(sb.size()), 32'd0);

    // Walk to the last row, then scroll with LF.
    for (int i = 0; i < ROWS - 2; i++) send(8'h0A);
    check("last_row", 32'(cur_row), 32'd29);
    send(8'h0A);
    check("scroll_busy", 32'(in_ready), 32'd0);
    wait_ready(n);
    check("scroll_cycles", 32'(n), 32'd81);
    check("scroll_top_row", 32'(top_row), 32'd1);
    check("scroll_top_addr", 32'(top_addr), 32'd80);
    check("scroll_sb_empty", 32'(sb.size()), 32'd0);
    send(8'h5A);
    idle(1);
    check("z_sb_empty", 32'(sb.size()), 32'd0);

    // Backspace, CR overwrite, and ignored bytes.
    send(8'h0D);
    send(8'h08);
    idle(1);
    check("bs_at_col0", 32'(cur_col), 32'd0);
    send(8'h78);
    send(8'h0D);
    send(8'h79);
    send(8'h78);
    send(8'h78);
    send(8'h08);
    check("bs_decrement", 32'(cur_col), 32'd2);
    send(8'h7F);
    send(8'h80);
    send(8'hFF);
    send(8'h01);
    idle(1);
    check("ignored_cursor", 32'({cur_row, cur_col}), 32'({5'd29, 7'd2}));
    check("ignored_sb_empty", 32'(sb.size()), 32'd0);

    // Three more LF scrolls, then a scroll caused by the last column.
    for (int k = 0; k < 3; k++) begin
      send(8'h0A);
      wait_ready(n);
      check("lf_scroll_cycles", 32'(n), 32'd81);
    end
    send(8'h0D);
    for (int i = 0; i < COLS - 1; i++) send(8'(8'h30 + (i % 10)));
    send(8'h21);
    check("wrap_scroll_busy", 32'(in_ready), 32'd0);
    wait_ready(n);
    check("wrap_scroll_cycles", 32'(n), 32'd81);
    check("top_row_5", 32'(top_row), 32'd5);
    check("top_addr_400", 32'(top_addr), 32'd400);
    check("wrap_cursor", 32'({cur_row, cur_col}), 32'({5'd29, 7'd0}));
    check("wrap_sb_empty", 32'(sb.size()), 32'd0);

    // Form feed, with the next byte held valid throughout the clear.
    send(8'h0C);
    check("ff_top_row", 32'(top_row), 32'd0);
    check("ff_cursor", 32'({cur_row, cur_col}), 32'd0);
    in_data  = 8'h51;
    in_valid = 1'b1;
    check("ff_busy", 32'(in_ready), 32'd0);
    wait_ready(n);
    check("ff_cycles", 32'(n), 32'd2400);
    send(8'h51);
    idle(1);
    check("ff_q_sb_empty", 32'(sb.size()), 32'd0);
    check("ff_top_addr", 32'(top_addr), 32'd0);
    check("ff_q_cur_col", 32'(cur_col), 32'd1);

    idle(5);
    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
